// File: rtl/cmos_capture_win.sv
// DVP capture front-end on the sensor pixel clock: pairs bytes into pixels, crops a
// programmable window, skips start-up frames and flags short lines / short frames.
module cmos_capture_win #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned X_W         = 12,
   parameter int unsigned Y_W         = 12,
   parameter int unsigned SKIP_FRAMES = 12,
   parameter bit          VSYNC_POL   = 1'b1
) (
   input  logic                CMOS_PCLK,
   input  logic                iRST_N,
   input  logic                init_done,
   input  logic                cmos_vsync,
   input  logic                cmos_href,
   input  logic [DATA_W-1:0]   cmos_data,
   input  logic                cfg_enable,
   input  logic                cfg_mode,
   input  logic                cfg_swap,
   input  logic [X_W-1:0]      cfg_x_start,
   input  logic [X_W-1:0]      cfg_width,
   input  logic [Y_W-1:0]      cfg_y_start,
   input  logic [Y_W-1:0]      cfg_height,
   input  logic                err_clr,
   output logic [2*DATA_W-1:0] pix_data,
   output logic                pix_valid,
   output logic                pix_sof,
   output logic                pix_eol,
   output logic                frame_valid,
   output logic [15:0]         frame_cnt,
   output logic [1:0]          err_flags
);

   localparam int unsigned SkipW = (SKIP_FRAMES < 2) ? 1 : $clog2(SKIP_FRAMES + 1);
   localparam logic [SkipW-1:0] SkipMax = SkipW'(SKIP_FRAMES);

   logic                vact_q, href_q, phase_q, run_q;
   logic [DATA_W-1:0]   b0_q;
   logic [X_W-1:0]      x_q, xs_q, width_q;
   logic [Y_W-1:0]      y_q, ys_q, height_q;
   logic                mode_q, swap_q;
   logic [SkipW-1:0]    skip_q, skip_d;

   logic                active_v, line_act, sof, eof, eol, pix_done, run_eff, emit;
   logic [X_W:0]        x_end;
   logic [Y_W:0]        y_end;
   logic                x_in, y_in, x_last;
   logic [1:0]          err_set;
   logic [2*DATA_W-1:0] pix_next;

   assign active_v = (cmos_vsync != VSYNC_POL);
   assign line_act = active_v & cmos_href;
   assign sof      = active_v & ~vact_q;
   assign eof      = ~active_v & vact_q;
   assign eol      = active_v & href_q & ~cmos_href;
   assign pix_done = line_act & phase_q;

   // init_done dropping kills the frame in the same cycle, before run_q clears
   assign run_eff  = run_q & init_done;

   // One extra bit on the window ends so xs+w / ys+h never wrap
   assign x_end  = {1'b0, xs_q} + {1'b0, width_q};
   assign y_end  = {1'b0, ys_q} + {1'b0, height_q};
   assign x_in   = (x_q >= xs_q) && ({1'b0, x_q} < x_end);
   assign y_in   = (y_q >= ys_q) && ({1'b0, y_q} < y_end);
   assign x_last = (({1'b0, x_q} + (X_W+1)'(1)) == x_end);
   assign emit   = pix_done & run_eff & x_in & y_in;

   assign err_set[0] = eol & y_in & ({1'b0, x_q} < x_end);
   assign err_set[1] = eof & run_eff & ({1'b0, y_q} < y_end);

   always_comb begin
      if (mode_q) begin
         pix_next = {{DATA_W{1'b0}}, (swap_q ? cmos_data : b0_q)};
      end else begin
         pix_next = swap_q ? {cmos_data, b0_q} : {b0_q, cmos_data};
      end
   end

   // Skip counter saturates at SKIP_FRAMES; frame_valid follows it while init_done holds
   always_comb begin
      skip_d = skip_q;
      if (!init_done) begin
         skip_d = '0;
      end else if (eof && (skip_q != SkipMax)) begin
         skip_d = skip_q + SkipW'(1);
      end
   end

   always_ff @(posedge CMOS_PCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         vact_q      <= 1'b0;
         href_q      <= 1'b0;
         phase_q     <= 1'b0;
         b0_q        <= '0;
         x_q         <= '0;
         y_q         <= '0;
         xs_q        <= '0;
         width_q     <= '0;
         ys_q        <= '0;
         height_q    <= '0;
         mode_q      <= 1'b0;
         swap_q      <= 1'b0;
         run_q       <= 1'b0;
         skip_q      <= '0;
         frame_valid <= 1'b0;
         frame_cnt   <= '0;
         err_flags   <= '0;
         pix_data    <= '0;
         pix_valid   <= 1'b0;
         pix_sof     <= 1'b0;
         pix_eol     <= 1'b0;
      end else begin
         vact_q  <= active_v;
         href_q  <= cmos_href;
         phase_q <= line_act & ~phase_q;
         if (line_act && !phase_q) begin
            b0_q <= cmos_data;
         end

         if (!line_act) begin
            x_q <= '0;
         end else if (pix_done) begin
            x_q <= x_q + X_W'(1);
         end

         if (sof) begin
            y_q <= '0;
         end else if (eol) begin
            y_q <= y_q + Y_W'(1);
         end

         if (sof) begin
            xs_q     <= cfg_x_start;
            width_q  <= cfg_width;
            ys_q     <= cfg_y_start;
            height_q <= cfg_height;
            mode_q   <= cfg_mode;
            swap_q   <= cfg_swap;
            run_q    <= cfg_enable & frame_valid & init_done;
         end else if (!init_done) begin
            run_q <= 1'b0;
         end

         skip_q      <= skip_d;
         frame_valid <= init_done & (skip_d == SkipMax);

         if (eof && run_eff) begin
            frame_cnt <= frame_cnt + 16'd1;
         end

         if (err_clr) begin
            err_flags <= '0;
         end else begin
            err_flags <= err_flags | err_set;
         end

         pix_valid <= emit;
         pix_sof   <= emit & (x_q == xs_q) & (y_q == ys_q);
         pix_eol   <= emit & x_last;
         if (emit) begin
            pix_data <= pix_next;
         end
      end
   end

endmodule

// File: doc/cmos_capture_win.md
Name: cmos_capture_win

Overview:
Parametrised DVP camera capture front-end, clocked by the sensor pixel clock. Assembles byte pairs into pixels and crops a run-time-programmable window anywhere in the sensor frame. Selects RGB565 or Y-only (YUV422) output. Suppresses the first frames after sensor init, flags malformed lines and frames, and drives a pixel stream into the SDRAM write FIFO.

Parameters:
DATA_W, 8, sensor data bus width; pix_data is 2*DATA_W.
X_W, 12, width of the column counter and the X config fields.
Y_W, 12, width of the row counter and the Y config fields.
SKIP_FRAMES, 12, number of complete frames discarded after init_done rises (0 = none discarded).
VSYNC_POL, 1, 1: VSYNC high = vertical blanking (OV7670); 0: VSYNC low = blanking.

Ports:
CMOS_PCLK  in  1  pixel clock; all logic on rising edge.
iRST_N  in  1  asynchronous, active-low reset.
init_done  in  1  SCCB configuration complete (level).
cmos_vsync  in  1  sensor VSYNC.
cmos_href  in  1  sensor HREF; high = active line.
cmos_data  in  DATA_W  sensor data.
cfg_enable  in  1  capture enable.
cfg_mode  in  1  0: RGB565 pair; 1: Y-only.
cfg_swap  in  1  1: swap the byte order within the pair.
cfg_x_start  in  X_W  first window column, in pixels.
cfg_width  in  X_W  window width, in pixels.
cfg_y_start  in  Y_W  first window row.
cfg_height  in  Y_W  window height, in rows.
err_clr  in  1  clears err_flags.
pix_data  out  2*DATA_W  pixel.
pix_valid  out  1  one-cycle pixel strobe.
pix_sof  out  1  qualifies the first window pixel of a frame.
pix_eol  out  1  qualifies the last window pixel of a line.
frame_valid  out  1  skip period complete.
frame_cnt  out  16  count of emitted frames.
err_flags  out  2  sticky flags; bit0 = short line, bit1 = short frame.

Behaviour:
- Reset (asynchronous) clears every output, counter and shadow register to 0. The synchroniser flops reset to the blanking level.
- The raw cmos_vsync is normalised to active_v = (cmos_vsync != VSYNC_POL).
- Edge detection uses one registered copy each of active_v and cmos_href:
  - SOF = active_v rising.
  - EOF = active_v falling.
  - EOL = cmos_href falling while active_v is high.
- Shadowing at SOF:
  - All cfg_* inputs are latched into shadow registers.
  - run = cfg_enable & frame_valid is latched.
  - A mid-frame config change has no effect until the next SOF.
- Byte phase:
  - Toggles on every cycle with active_v & cmos_href; forced to 0 otherwise.
  - Phase 0 stores the first byte. Phase 1 completes a pixel.
  - An odd trailing byte at HREF fall is discarded.
- Pixel assembly:
  - Mode 0: {b0,b1}; with swap, {b1,b0}.
  - Mode 1: {0,b0}; with swap, {0,b1}.
- Counters:
  - x counts completed pixels in the line; cleared at EOL and outside HREF.
  - y counts EOL events; cleared at SOF.
- Window test:
  - in_win = x >= xs && x < xs+w && y >= ys && y < ys+h.
  - Sums are computed at X_W+1 / Y_W+1 bits, so there is no wrap-around.
  - w = 0 or h = 0 gives no output for that frame.
- Output timing:
  - pix_valid pulses exactly one cycle after the edge that samples the second byte, and only when run & in_win.
  - pix_data holds its value between strobes.
  - pix_sof is asserted with the pixel at (xs, ys).
  - pix_eol is asserted with the pixel at x = xs+w-1.
- Frame skip:
  - Skip counter increments on EOF while init_done is high.
  - frame_valid sets on the EOF at which the counter has reached SKIP_FRAMES; the counter saturates there.
  - init_done low clears the counter and frame_valid on the next edge. A frame in progress stops emitting immediately.
- frame_cnt increments, with 16-bit wrap, on each EOF of a frame with run = 1.
- err_flags:
  - bit0 sets on an EOL where ys <= y < ys+h and x < xs+w.
  - bit1 sets on an EOF of a run frame where y < ys+h.
  - err_clr wins over a simultaneous set.
- SOF and EOF in consecutive cycles are both honoured. A glitch frame with no lines is counted as a frame.

Test Plan:
1. SKIP_FRAMES=2; init_done high; drive 3 frames of 4 lines × 8 px, window 0,0,8,4 -> frame_valid rises at EOF of frame 2; frame 3 gives 32 pix_valid, one pix_sof, 4 pix_eol; frame_cnt=1.
2. Window xs=2, w=3, ys=1, h=2, ramp data -> exactly 6 pixels from columns 2–4 of rows 1–2; pix_eol on column 4.
3. Bytes 0xAB,0xCD in mode0/swap0 -> pix_data 0xABCD; mode0/swap1 -> 0xCDAB; mode1 -> 0x00AB; mode1/swap1 -> 0x00CD.
4. Change cfg_x_start mid-frame -> current frame is unchanged and the next frame uses the new value. Drop cfg_enable mid-frame -> that frame still completes, and the next frame emits nothing.
5. Line of 5 px with window w=8, plus a frame of 3 lines with h=4 -> err_flags=2'b11; assert err_clr -> 2'b00.
6. Reset asserted mid-line, and init_done pulsed low mid-frame -> all outputs 0 immediately; the skip count restarts from 0.
